// File: rtl/pwm_update_scheduler_if.sv
// Register-write bus between the SPI peripheral and the PWM update scheduler.
// The requester drives valid/addr/data and holds them while ready is low.
interface pwm_update_scheduler_if;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/pwm_update_scheduler.sv
// PWM update scheduler: shadow/active control registers, PWM timebase and
// 16 registered output pins. Shadow registers are committed only at a PWM
// period wrap, so register writes never produce a partial or glitched period.
module pwm_update_scheduler #(
  parameter int unsigned PRESCALE   = 4,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pwm_update_scheduler_if.slave wr,
  output logic [7:0]            uo_out,
  output logic [7:0]            uio_out,
  output logic                  period_start,
  output logic                  update_pending
);

  localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(PRESCALE - 1);
  localparam logic [7:0]            PWM_LAST      = 8'd254;
  localparam logic [7:0]            DUTY_FULL     = 8'd255;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  logic [PRESCALE_W-1:0] prescaler;
  logic [7:0]            pwm_cnt;
  logic                  tick;
  logic                  wrap;
  logic                  commit_now;
  logic                  accept;
  logic                  addr_hit;

  logic [15:0] shadow_en_out;
  logic [15:0] shadow_en_pwm;
  logic [7:0]  shadow_duty;
  logic [15:0] active_en_out;
  logic [15:0] active_en_pwm;
  logic [7:0]  active_duty;

  logic [15:0] pin_level;

  // With PRESCALE=1 the prescaler never leaves zero, so tick is always high.
  assign tick       = (prescaler == PRESCALE_LAST);
  assign wrap       = tick && (pwm_cnt == PWM_LAST);
  assign commit_now = wrap && update_pending;

  // A write is held off during the commit cycle so it lands wholly before or after it.
  assign wr.wr_ready = !commit_now;
  assign accept      = wr.wr_valid && wr.wr_ready;
  assign addr_hit    = (wr.wr_addr <= ADDR_DUTY);

  // Prescaler divides clk down to one PWM step every PRESCALE cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PRESCALE_W'(1);
    end
  end

  // PWM step counter runs 0..254, giving 255 steps per period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      if (pwm_cnt == PWM_LAST) begin
        pwm_cnt <= '0;
      end else begin
        pwm_cnt <= pwm_cnt + 8'd1;
      end
    end
  end

  // Period marker is high for the single cycle following the wrap cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
    end
  end

  // Shadow registers capture accepted writes; out-of-range addresses are consumed silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_en_out  <= '0;
      shadow_en_pwm  <= '0;
      shadow_duty    <= '0;
      update_pending <= 1'b0;
    end else if (commit_now) begin
      update_pending <= 1'b0;
    end else if (accept && addr_hit) begin
      update_pending <= 1'b1;
      case (wr.wr_addr)
        ADDR_EN_OUT_LO: shadow_en_out[7:0]  <= wr.wr_data;
        ADDR_EN_OUT_HI: shadow_en_out[15:8] <= wr.wr_data;
        ADDR_EN_PWM_LO: shadow_en_pwm[7:0]  <= wr.wr_data;
        ADDR_EN_PWM_HI: shadow_en_pwm[15:8] <= wr.wr_data;
        ADDR_DUTY:      shadow_duty         <= wr.wr_data;
        default: ;
      endcase
    end
  end

  // All active registers load together at a wrap so the next period sees one consistent set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_en_out <= '0;
      active_en_pwm <= '0;
      active_duty   <= '0;
    end else if (commit_now) begin
      active_en_out <= shadow_en_out;
      active_en_pwm <= shadow_en_pwm;
      active_duty   <= shadow_duty;
    end
  end

  // Pin level: disabled pins are low, non-PWM pins high, full duty high, else compare.
  always_comb begin
    pin_level = '0;
    for (int i = 0; i < 16; i++) begin
      if (!active_en_out[i]) begin
        pin_level[i] = 1'b0;
      end else if (!active_en_pwm[i]) begin
        pin_level[i] = 1'b1;
      end else if (active_duty == DUTY_FULL) begin
        pin_level[i] = 1'b1;
      end else begin
        pin_level[i] = (pwm_cnt < active_duty);
      end
    end
  end

  // Output pins are registered so they never glitch on combinational decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uo_out  <= '0;
      uio_out <= '0;
    end else begin
      uo_out  <= pin_level[7:0];
      uio_out <= pin_level[15:8];
    end
  end

endmodule

// File: tb/tb_pwm_update_scheduler.sv
// Testbench for pwm_update_scheduler: directed scenarios plus random writes,
// every cycle compared against a period-arithmetic reference model.
module tb_pwm_update_scheduler;

  localparam int P      = 4;
  localparam int PERIOD = 255 * P;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic       period_start;
  logic       update_pending;

  pwm_update_scheduler_if bus ();

  pwm_update_scheduler #(
    .PRESCALE   (P),
    .PRESCALE_W (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr             (bus),
    .uo_out         (uo_out),
    .uio_out        (uio_out),
    .period_start   (period_start),
    .update_pending (update_pending)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: time is a count of clk edges since reset release;
  // registers are kept per address as the register map describes them.
  int unsigned cyc;
  logic [7:0]  m_shadow [5];
  logic [7:0]  m_active [5];
  logic        m_pending;
  logic [15:0] m_pins;
  logic        m_pstart;
  logic        last_accept;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t, cyc=%0d)", tag, actual, expected, $time, cyc);
    end
  endtask

  function automatic logic m_wrap();
    return ((cyc + 1) % PERIOD) == 0;
  endfunction

  function automatic logic [15:0] m_levels();
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    int          step;
    int          high_steps;
    logic [15:0] lv;
    en_out     = {m_active[1], m_active[0]};
    en_pwm     = {m_active[3], m_active[2]};
    step       = (cyc / P) % 255;
    high_steps = (m_active[4] == 8'hFF) ? 255 : int'(m_active[4]);
    lv = '0;
    for (int i = 0; i < 16; i++)
      lv[i] = en_out[i] && (!en_pwm[i] || (step < high_steps));
    return lv;
  endfunction

  task automatic model_reset();
    cyc = 0;
    for (int i = 0; i < 5; i++) begin
      m_shadow[i] = 8'h00;
      m_active[i] = 8'h00;
    end
    m_pending = 1'b0;
    m_pins    = '0;
    m_pstart  = 1'b0;
  endtask

  // One clock: check ready, advance the model across the edge, check outputs.
  task automatic tick_cycle();
    logic        rdy;
    logic [15:0] next_pins;
    logic        next_pstart;
    rdy = !(m_wrap() && m_pending);
    checkOutput("wr_ready", bus.wr_ready, rdy);
    last_accept = bus.wr_valid && rdy;
    next_pins   = m_levels();
    next_pstart = m_wrap();
    if (m_wrap() && m_pending) begin
      m_active  = m_shadow;
      m_pending = 1'b0;
    end else if (last_accept && bus.wr_addr <= 7'h04) begin
      m_shadow[int'(bus.wr_addr)] = bus.wr_data;
      m_pending = 1'b1;
    end
    @(posedge clk);
    cyc++;
    m_pins   = next_pins;
    m_pstart = next_pstart;
    @(negedge clk);
    checkOutput("uo_out", uo_out, m_pins[7:0]);
    checkOutput("uio_out", uio_out, m_pins[15:8]);
    checkOutput("period_start", period_start, m_pstart);
    checkOutput("update_pending", update_pending, m_pending);
  endtask

  task automatic applyStimulus(input logic [6:0] addr, input logic [7:0] data);
    int tries;
    tries = 0;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = addr;
    bus.wr_data  = data;
    do begin
      tick_cycle();
      tries++;
    end while (!last_accept && tries < 3);
    if (!last_accept) checkOutput("accept_timeout", 32'd0, 32'd1);
    bus.wr_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.wr_valid = 1'b0;
    repeat (n) tick_cycle();
  endtask

  task automatic wait_period_start(output int n);
    bus.wr_valid = 1'b0;
    n = 0;
    do begin
      tick_cycle();
      n++;
    end while (!period_start && n < PERIOD + 8);
    if (!period_start) checkOutput("pstart_timeout", period_start, 1'b1);
  endtask

  // Count high cycles of pin 0 over one full period, optionally queuing the next duty.
  task automatic measure_period(input logic do_wr, input logic [7:0] next_duty,
                                input int exp_highs, input string tag);
    int highs;
    highs = 0;
    for (int i = 0; i < PERIOD; i++) begin
      bus.wr_valid = do_wr && (i == 0);
      bus.wr_addr  = 7'h04;
      bus.wr_data  = next_duty;
      tick_cycle();
      if (uo_out[0]) highs++;
    end
    bus.wr_valid = 1'b0;
    checkOutput(tag, highs, exp_highs);
    checkOutput("pstart_cadence", period_start, 1'b1);
  endtask

  // Main sequence.
  initial begin
    int n;
    int r;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    last_accept  = 1'b0;
    model_reset();

    // Reset values.
    repeat (2) @(negedge clk);
    checkOutput("rst_uo_out", uo_out, 8'h00);
    checkOutput("rst_uio_out", uio_out, 8'h00);
    checkOutput("rst_period_start", period_start, 1'b0);
    checkOutput("rst_update_pending", update_pending, 1'b0);
    checkOutput("rst_wr_ready", bus.wr_ready, 1'b1);
    rst_n = 1'b1;

    // First write waits for the first wrap before reaching the pins.
    applyStimulus(7'h00, 8'hFF);
    checkOutput("pending_after_write", update_pending, 1'b1);
    wait_period_start(n);
    checkOutput("first_wrap_cycle", cyc, PERIOD);
    checkOutput("uo_at_pstart", uo_out, 8'h00);
    idle(1);
    checkOutput("uo_after_commit", uo_out, 8'hFF);
    checkOutput("pending_after_commit", update_pending, 1'b0);

    // PWM on pin 0 only, then a duty sweep one period at a time.
    applyStimulus(7'h01, 8'hFF);
    applyStimulus(7'h02, 8'h01);
    applyStimulus(7'h03, 8'h00);
    applyStimulus(7'h04, 8'h80);
    wait_period_start(n);
    measure_period(1'b1, 8'h00, 128 * P, "duty_80_highs");
    measure_period(1'b1, 8'h01, 0, "duty_00_highs");
    measure_period(1'b1, 8'hFE, 1 * P, "duty_01_highs");
    measure_period(1'b1, 8'hFF, 254 * P, "duty_FE_highs");
    measure_period(1'b1, 8'h80, 255 * P, "duty_FF_highs");

    // Write presented on the exact commit cycle stalls for one cycle.
    applyStimulus(7'h00, 8'h0F);
    n = 0;
    while (!(m_wrap() && m_pending) && n < PERIOD + 8) begin
      tick_cycle();
      n++;
    end
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 7'h04;
    bus.wr_data  = 8'h40;
    checkOutput("stall_ready", bus.wr_ready, 1'b0);
    tick_cycle();
    checkOutput("stall_pending_cleared", update_pending, 1'b0);
    tick_cycle();
    checkOutput("stall_pending_set", update_pending, 1'b1);
    bus.wr_valid = 1'b0;
    wait_period_start(n);
    measure_period(1'b0, 8'h00, 64 * P, "duty_40_highs");

    // Writes above the register map are consumed and dropped.
    applyStimulus(7'h05, 8'hAA);
    checkOutput("drop05_pending", update_pending, 1'b0);
    applyStimulus(7'h7F, 8'hAA);
    checkOutput("drop7F_pending", update_pending, 1'b0);
    idle(4);

    // Random writes; a stalled request is held until accepted.
    for (int k = 0; k < 3000; k++) begin
      if (!(bus.wr_valid && !last_accept)) begin
        r            = int'($urandom_range(0, 7));
        bus.wr_valid = ($urandom_range(0, 2) == 0);
        bus.wr_addr  = (r <= 5) ? 7'(r) : 7'($urandom_range(6, 127));
        bus.wr_data  = 8'($urandom);
      end
      tick_cycle();
    end
    bus.wr_valid = 1'b0;

    // Reset mid-period with a pending duty write: the write is lost.
    applyStimulus(7'h04, 8'h33);
    idle(100);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_uo_out", uo_out, 8'h00);
    checkOutput("midrst_uio_out", uio_out, 8'h00);
    checkOutput("midrst_pending", update_pending, 1'b0);
    checkOutput("midrst_period_start", period_start, 1'b0);
    repeat (3) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    wait_period_start(n);
    checkOutput("midrst_first_wrap", n, PERIOD);
    checkOutput("midrst_no_commit_pending", update_pending, 1'b0);
    wait_period_start(n);
    checkOutput("midrst_pstart_interval", n, PERIOD);
    checkOutput("midrst_outputs_idle", {uio_out, uo_out}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_update_scheduler.md
Name: pwm_update_scheduler

Overview:
- Sits between the SPI register-write peripheral and the 16 output pins.
- Holds shadow copies of the five control registers: output enables, PWM enables and duty cycle.
- Runs the PWM timebase and commits shadow registers to active registers only at a PWM period boundary, so SPI writes never cause glitched or partial PWM periods.
- Generates the 16 registered output levels from the active registers.

Parameters:
- PRESCALE, 4, number of clk cycles per PWM step; legal range 1..65535.
- PRESCALE_W, 16, width of the prescaler counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- wr_valid  input  1  register write request from the SPI peripheral
- wr_addr  input  7  register address
- wr_data  input  8  register write data
- wr_ready  output  1  write accepted this cycle when wr_valid && wr_ready
- uo_out  output  8  output pins 7..0
- uio_out  output  8  output pins 15..8
- period_start  output  1  one-cycle pulse at each PWM period wrap
- update_pending  output  1  shadow holds data not yet committed

Behaviour:
- Register map, shadow and active copies:
  - 0x00 en_out[7:0], 0x01 en_out[15:8]
  - 0x02 en_pwm[7:0], 0x03 en_pwm[15:8]
  - 0x04 duty[7:0]
- Reset values (async on rst_n low):
  - All shadow and active registers, prescaler, pwm_cnt, uo_out, uio_out, period_start and update_pending are 0.
  - wr_ready is 1.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick = (prescaler == PRESCALE-1).
  - PRESCALE=1 makes tick constant 1.
- PWM counter (8 bits):
  - Advances on tick, 0..254, then wraps 254->0. One period = 255 steps = 255*PRESCALE clk.
- wrap = tick && pwm_cnt==254.
  - period_start is registered: high for exactly the one cycle after the wrap cycle.
- Commit:
  - commit_now = wrap && update_pending.
  - On commit_now, all five active registers load from shadow in one cycle, and update_pending clears.
  - The first period after commit (pwm_cnt==0) uses the new values.
- Write handshake:
  - wr_ready = !commit_now (combinational).
  - Accept = wr_valid && wr_ready.
  - Accepted write to 0x00..0x04: updates that shadow register on the next edge and sets update_pending.
  - Accepted write to address >0x04: consumed and dropped; no state change, update_pending unaffected.
  - A write presented during a commit cycle stalls one cycle (requester holds wr_valid/addr/data). This guarantees each write lands wholly before or after a commit.
  - Multiple writes within a period: last value per address wins; all commit together.
- Output level for pin i (0..15), computed from active registers and the current pwm_cnt:
  - en_out[i]==0 -> 0.
  - else en_pwm[i]==0 -> 1.
  - else duty==255 -> 1.
  - else (pwm_cnt < duty).
  - duty==0 gives a constant 0; duty==d gives d high steps per 255.
- Output timing:
  - Outputs are registered: pin state reflects pwm_cnt/active values one clk later.
  - A commit changes pins on the cycle after the commit edge, at most.
- Reset mid-operation: everything returns to reset values immediately. Uncommitted shadow data is lost. Write acceptance resumes on the first clk after rst_n release.

Test Plan:
- Reset release, then write 0x00=0xFF -> uo_out stays 0x00 and update_pending=1 until the first wrap (clk 1020 with PRESCALE=4); uo_out=0xFF from the cycle after the commit; update_pending=0.
- en_out=0xFFFF, en_pwm=0x0001, duty=0x80 committed -> uo_out[0] high for 128 of 255 steps (512 of 1020 clk) per period; all other pins constant 1.
- duty sweep 0x00, 0x01, 0xFE, 0xFF on pin 0 -> high steps per period 0, 1, 254, 255 respectively (0xFF: no low cycles at all).
- Write 0x04=0x40 held with wr_valid on the exact commit cycle -> wr_ready=0 that cycle; write accepted the next cycle; duty 0x40 takes effect only at the following wrap.
- Write to 0x05 and 0x7F with data 0xAA -> accepted (wr_ready=1), update_pending remains 0, no output or register change.
- Assert rst_n low mid-period with pending duty write -> outputs 0 within the reset; after release no commit occurs at the next wrap (update_pending=0); period_start pulses every 1020 clk.
